// File: rtl/keypad_pkg.sv
// Shared types and key-code table for the 4x4 keypad scanner.
// Optional build macro: KEYPAD_GHOST_REJECT_EN.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_t;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Indexed by {row, col}; entry 0 is row 0 / column 0.
  localparam logic [0:15][3:0] KEY_CODE = {
    4'd1,     4'd2, 4'd3,     KEY_A,
    4'd4,     4'd5, 4'd6,     KEY_B,
    4'd7,     4'd8, 4'd9,     KEY_C,
    KEY_STAR, 4'd0, KEY_HASH, KEY_D
  };

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return KEY_CODE[{r, c}];
  endfunction

  // Row lines are active low; the lowest-index low row wins.
  function automatic logic [1:0] lowest_low(input logic [3:0] rs);
    if (!rs[0])      return 2'd0;
    else if (!rs[1]) return 2'd1;
    else if (!rs[2]) return 2'd2;
    else             return 2'd3;
  endfunction

  function automatic logic multi_low(input logic [3:0] rs);
    logic [3:0] low;
    low = ~rs;
    return (low & (low - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and lock-side signals of the scanner, bundled for port lists.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] button;
  logic       bstate;
  logic       key_valid;

  modport master (input row, output col, output button, output bstate, output key_valid);
  modport slave  (output row, input col, input button, input bstate, input key_valid);
endinterface

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low row lines.
module row_sync (
  input  logic       hwclk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      meta <= 4'b1111;
      q    <= 4'b1111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, press/release debounce, key encoding.
// Optional build macro: KEYPAD_GHOST_REJECT_EN (discard multi-row samples).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1200,
  parameter int DEBOUNCE_CYC = 240000
) (
  input logic               hwclk,
  input logic               rst_n,
  keypad_scanner_if.master  kp
);
  localparam int SW = $clog2(SCAN_DIV) + 1;
  localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYC);

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    lrow_q, lrow_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [3:0]    button_q, button_d;
  logic          bstate_q, bstate_d;
  logic          kv_q, kv_d;
  logic [3:0]    rs;
  logic          row_low;
  logic          ghost_scan;
  logic          ghost_press;

  row_sync u_row_sync (
    .hwclk (hwclk),
    .rst_n (rst_n),
    .d     (kp.row),
    .q     (rs)
  );

  assign row_low = ~rs[lrow_q];

`ifdef KEYPAD_GHOST_REJECT_EN
  assign ghost_scan  = multi_low(rs);
  assign ghost_press = |(~rs & ~(4'b0001 << lrow_q));
`else
  assign ghost_scan  = 1'b0;
  assign ghost_press = 1'b0;
`endif

  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      state_q  <= SCAN;
      idx_q    <= 2'd0;
      lrow_q   <= 2'd0;
      scnt_q   <= '0;
      dcnt_q   <= '0;
      button_q <= 4'd0;
      bstate_q <= 1'b0;
      kv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lrow_q   <= lrow_d;
      scnt_q   <= scnt_d;
      dcnt_q   <= dcnt_d;
      button_q <= button_d;
      bstate_q <= bstate_d;
      kv_q     <= kv_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lrow_d   = lrow_q;
    scnt_d   = scnt_q;
    dcnt_d   = dcnt_q;
    button_d = button_q;
    bstate_d = bstate_q;
    kv_d     = 1'b0;

    case (state_q)
      SCAN: begin
        if (scnt_q == SCAN_LAST) begin
          scnt_d = '0;
          if (rs != 4'b1111 && !ghost_scan) begin
            lrow_d  = lowest_low(rs);
            dcnt_d  = '0;
            state_d = DEB_PRESS;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end

      DEB_PRESS: begin
        if (!row_low || ghost_press) begin
          dcnt_d  = '0;
          idx_d   = idx_q + 2'd1;
          state_d = SCAN;
        end else if (dcnt_q >= DEB_MAX) begin
          dcnt_d   = '0;
          button_d = key_code(lrow_q, idx_q);
          bstate_d = 1'b1;
          kv_d     = 1'b1;
          state_d  = PRESSED;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      PRESSED: begin
        if (!row_low) begin
          dcnt_d  = '0;
          state_d = DEB_RELEASE;
        end
      end

      DEB_RELEASE: begin
        // A re-closing contact is bounce: keep the key held, no new strobe.
        if (row_low) begin
          state_d = PRESSED;
        end else if (dcnt_q >= DEB_MAX) begin
          dcnt_d   = '0;
          scnt_d   = '0;
          bstate_d = 1'b0;
          idx_d    = idx_q + 2'd1;
          state_d  = SCAN;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  assign kp.col       = ~(4'b0001 << idx_q);
  assign kp.button    = button_q;
  assign kp.bstate    = bstate_q;
  assign kp.key_valid = kv_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: a behavioural keypad (held keys short row to column) drives the scanner.
module tb_keypad_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int PRESS_BUDGET = 4 * 4 * SCAN_DIV + DEB + 40;

  logic        hwclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] held;
  logic [3:0]  row_model;
  int          checks = 0;
  int          errors = 0;
  int          kv_total = 0;
  int          kv_base = 0;
  string       layout = "123A456B789C*0#D";

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CYC (DEB)
  ) dut (
    .hwclk (hwclk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  always #5 hwclk = ~hwclk;

  // A held key pulls its row low while its column is driven low.
  always_comb begin
    row_model = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && kp.col[c] === 1'b0) row_model[r] = 1'b0;
  end
  assign kp.row = row_model;

  always @(posedge hwclk) if (kp.key_valid === 1'b1) kv_total++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] code_of(input int r, input int c);
    byte ch;
    ch = layout[r*4+c];
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    if (ch >= "A" && ch <= "D") return 4'(ch - "A" + 10);
    if (ch == "*") return 4'd14;
    return 4'd15;
  endfunction

  function automatic logic [3:0] col_of(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  task automatic wait_col(input logic [3:0] v, input bit equal, input int budget, output bit ok);
    int n;
    n = 0;
    while (((kp.col === v) != equal) && n < budget) begin
      step(1);
      n++;
    end
    ok = ((kp.col === v) == equal);
  endtask

  task automatic press_mask(input string tag, input logic [15:0] mask, input int c, input logic [3:0] code);
    int n;
    kv_base = kv_total;
    held = mask;
    n = 0;
    while (kp.bstate !== 1'b1 && n < PRESS_BUDGET) begin
      step(1);
      n++;
    end
    check({tag, "_bstate_rise"}, kp.bstate, 1'b1);
    check({tag, "_min_latency"}, (n > DEB), 1'b1);
    check({tag, "_kv_with_rise"}, kp.key_valid, 1'b1);
    check({tag, "_button"}, kp.button, code);
    check({tag, "_col_frozen"}, kp.col, col_of(c));
    step(1);
    check({tag, "_kv_one_cycle"}, kp.key_valid, 1'b0);
    step(4);
    check({tag, "_col_still"}, kp.col, col_of(c));
    check({tag, "_kv_count"}, kv_total - kv_base, 1);
  endtask

  task automatic press_key(input string tag, input int r, input int c);
    logic [15:0] m;
    m = '0;
    m[r*4+c] = 1'b1;
    press_mask(tag, m, c, code_of(r, c));
  endtask

  // At least DEB stable cycles after the sync delay must elapse before bstate drops.
  task automatic release_key(input string tag, input logic [3:0] code);
    held = '0;
    step(DEB + 1);
    check({tag, "_rel_hold"}, kp.bstate, 1'b1);
    step(4);
    check({tag, "_rel_done"}, kp.bstate, 1'b0);
    check({tag, "_button_kept"}, kp.button, code);
    check({tag, "_no_second_kv"}, kv_total - kv_base, 1);
  endtask

  task automatic press_bounce(input int hold);
    bit ok;
    bit saw_b;
    int kv0;
    kv0 = kv_total;
    wait_col(4'b1110, 1'b0, 40, ok);
    wait_col(4'b1110, 1'b1, 40, ok);
    check("bounce_sync_col0", ok, 1'b1);
    held = 16'h0001;
    step(hold);
    held = '0;
    saw_b = 1'b0;
    for (int n = 0; n < 30 && kp.col !== 4'b1101; n++) begin
      if (kp.bstate === 1'b1) saw_b = 1'b1;
      step(1);
    end
    check($sformatf("bounce%0d_resume_col1", hold), kp.col, 4'b1101);
    check($sformatf("bounce%0d_no_bstate", hold), saw_b, 1'b0);
    check($sformatf("bounce%0d_no_kv", hold), kv_total - kv0, 0);
  endtask

  initial begin
    int k;
    bit saw_b;
    int kv0;
    held = '0;

    // Reset and column rotation
    rst_n = 1'b0;
    step(2);
    check("rst_col", kp.col, 4'b1110);
    check("rst_button", kp.button, 4'd0);
    check("rst_bstate", kp.bstate, 1'b0);
    check("rst_kv", kp.key_valid, 1'b0);
    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step(1);
      check($sformatf("rotate_%0d", n), kp.col, col_of((n / 4) % 4));
    end

    // Key 5 press and clean release
    press_key("key5", 1, 1);
    release_key("key5", code_of(1, 1));

    // Press bounce on key 1
    press_bounce(3);
    for (int i = 0; i < 3; i++) press_bounce(int'($urandom_range(1, 5)));

    // Release bounce on key 8
    press_key("key8", 2, 1);
    held = '0;
    step(3);
    held = 16'h0200;
    step(2);
    check("relbounce_bstate", kp.bstate, 1'b1);
    check("relbounce_col", kp.col, col_of(1));
    release_key("key8", code_of(2, 1));

    // Encoding: #, D, 0, then random keys
    press_key("hash", 3, 2);
    release_key("hash", 4'd15);
    press_key("keyD", 3, 3);
    release_key("keyD", 4'd13);
    press_key("key0", 3, 1);
    release_key("key0", 4'd0);
    for (int i = 0; i < 6; i++) begin
      k = int'($urandom_range(0, 15));
      press_key($sformatf("rnd%0d", k), k / 4, k % 4);
      release_key($sformatf("rnd%0d", k), code_of(k / 4, k % 4));
    end

    // Keys 1 and 4 together in column 0
`ifdef KEYPAD_GHOST_REJECT_EN
    kv0 = kv_total;
    held = 16'h0011;
    saw_b = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (kp.bstate === 1'b1) saw_b = 1'b1;
      step(1);
    end
    held = '0;
    check("ghost_no_bstate", saw_b, 1'b0);
    check("ghost_no_kv", kv_total - kv0, 0);
    step(4 * SCAN_DIV * 2);
`else
    press_mask("dual", 16'h0011, 0, code_of(0, 0));
    release_key("dual", code_of(0, 0));
`endif

    // Reset while a key is held
    press_key("rstkey", 1, 1);
    rst_n = 1'b0;
    step(1);
    check("midrst_bstate", kp.bstate, 1'b0);
    check("midrst_kv", kp.key_valid, 1'b0);
    check("midrst_button", kp.button, 4'd0);
    check("midrst_col", kp.col, 4'b1110);
    held = '0;
    step(1);
    rst_n = 1'b1;
    step(3);
    check("postrst_col0", kp.col, 4'b1110);
    step(1);
    check("postrst_col1", kp.col, 4'b1101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
